// File: rtl/result_unloader_if.sv
// result_unloader_if: SRAM read port plus output beat stream of the result unloader.
//   master (unloader): drives rd_en/rd_addr, consumes rd_data;
//                      drives out_data/out_valid/out_last/out_index, consumes out_ready.
//   slave  (SRAM + host/file-writer side): the mirror image.
interface result_unloader_if #(
  parameter int Addr_Width = 4,
  parameter int Beat_Width = 16
);
  logic                  rd_en;
  logic [Addr_Width-1:0] rd_addr;
  logic [Beat_Width-1:0] rd_data;
  logic [Beat_Width-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [Addr_Width-1:0] out_index;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_last, out_index,
    input  rd_data, out_ready
  );
  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_last, out_index,
    output rd_data, out_ready
  );
endinterface

// File: rtl/result_unloader.sv
// result_unloader: drains the dot-product output SRAM after computation and
// streams it to the host with valid/ready flow control.
//   clk            single clock, rising edge
//   Unload_reset_n async active-low reset
//   start          one-cycle unload request, sampled only in IDLE
//   busy / done    busy while unloading; done pulses one cycle after the last beat
//   bus            result_unloader_if.master: SRAM read port + output stream
// Reads are issued against a 2-entry credit (buffer occupancy + read in flight),
// so the buffer cannot overflow and beats are never dropped or duplicated.
// The SRAM word addressed by the registered rd_en/rd_addr is captured on the
// edge that closes that cycle, so only the read currently on rd_en is in flight.

// One lane (Data_Width_Out bits) of the 2-entry beat buffer.
module result_unloader_lane #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          wsel,
  input  logic          rsel,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [1:0][DW-1:0] mem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mem_q       <= '0;
    else if (push) mem_q[wsel] <= din;
  end

  assign dout = mem_q[rsel];
endmodule

module result_unloader #(
  parameter int Addr_Width     = 4,
  parameter int Ram_Depth      = 1 << Addr_Width,
  parameter int Para_Deg       = 1,
  parameter int Data_Width_Out = 16,
  parameter int Num_Beats      = Ram_Depth / Para_Deg
) (
  input  logic               clk,
  input  logic               Unload_reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  result_unloader_if.master  bus
);
  localparam int                    CW       = Addr_Width + 1;
  localparam logic [CW-1:0]         NB       = CW'(Num_Beats);
  localparam logic [Addr_Width-1:0] LAST_IDX = Addr_Width'(Num_Beats - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic [Addr_Width-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]         issued_q, issued_d;

  // beat buffer bookkeeping
  logic [1:0]                  cnt_q;
  logic                        wr_ptr_q, rd_ptr_q;
  logic [1:0][Addr_Width-1:0]  idx_q;
  logic                        push, pop;
  logic [2:0]                  occ_next;

  logic [Para_Deg-1:0][Data_Width_Out-1:0] rd_lanes, head_lanes;

  assign push          = rd_en_q;
  assign bus.out_valid = (cnt_q != 2'd0);
  assign pop           = bus.out_valid && bus.out_ready;
  // Occupancy after this edge, counting the read on rd_en now as already landed.
  assign occ_next      = {1'b0, cnt_q} + {2'b00, rd_en_q} - {2'b00, pop};

  assign bus.out_index = idx_q[rd_ptr_q];
  assign bus.out_last  = bus.out_valid && (bus.out_index == LAST_IDX);
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign busy          = busy_q;
  assign done          = done_q;

  assign rd_lanes      = bus.rd_data;
  assign bus.out_data  = head_lanes;

  for (genvar k = 0; k < Para_Deg; k++) begin : g_lane
    result_unloader_lane #(.DW(Data_Width_Out)) u_lane (
      .clk  (clk),
      .rst_n(Unload_reset_n),
      .push (push),
      .wsel (wr_ptr_q),
      .rsel (rd_ptr_q),
      .din  (rd_lanes[k]),
      .dout (head_lanes[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    issued_d  = issued_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // buffer is empty here, so the first read goes out immediately
          state_d   = S_RUN;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
          issued_d  = CW'(1);
        end
      end
      S_RUN: begin
        if (issued_q < NB && occ_next < 3'd2) begin
          rd_en_d   = 1'b1;
          rd_addr_d = issued_q[Addr_Width-1:0];
          issued_d  = issued_q + CW'(1);
        end
        if (pop && bus.out_last) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Unload_reset_n) begin
    if (!Unload_reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      issued_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      issued_q  <= issued_d;
    end
  end

  // Push and pop may coincide; when full, the write lands in the slot being popped.
  always_ff @(posedge clk or negedge Unload_reset_n) begin
    if (!Unload_reset_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      cnt_q <= occ_next[1:0];
      if (push) begin
        idx_q[wr_ptr_q] <= rd_addr_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end
endmodule

// File: tb/tb_result_unloader.sv
module tb_result_unloader;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst_n, start0, start1, rdy, sel;
  logic busy0, busy1, done0, done1;
  int   tests = 0, fails = 0;
  int   cyc = 0, c0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  result_unloader_if #(.Addr_Width(AW), .Beat_Width(16)) bus0 ();
  result_unloader_if #(.Addr_Width(AW), .Beat_Width(32)) bus1 ();

  result_unloader #(.Addr_Width(AW)) u0 (
    .clk(clk), .Unload_reset_n(rst_n), .start(start0),
    .busy(busy0), .done(done0), .bus(bus0));
  result_unloader #(.Addr_Width(AW), .Para_Deg(2)) u1 (
    .clk(clk), .Unload_reset_n(rst_n), .start(start1),
    .busy(busy1), .done(done1), .bus(bus1));

  // SRAM models: word at rd_addr, taken by the DUT at the edge closing the rd_en cycle
  logic [15:0] mem0 [16];
  logic [31:0] mem1 [8];
  assign bus0.rd_data   = mem0[bus0.rd_addr];
  assign bus1.rd_data   = mem1[bus1.rd_addr[2:0]];
  assign bus0.out_ready = rdy;
  assign bus1.out_ready = rdy;

  // observed DUT selected by sel
  logic [31:0]   m_data;
  logic [AW-1:0] m_idx, m_rd_addr;
  logic          m_valid, m_last, m_busy, m_done, m_rd_en;
  assign m_data    = sel ? bus1.out_data  : {16'h0, bus0.out_data};
  assign m_idx     = sel ? bus1.out_index : bus0.out_index;
  assign m_valid   = sel ? bus1.out_valid : bus0.out_valid;
  assign m_last    = sel ? bus1.out_last  : bus0.out_last;
  assign m_busy    = sel ? busy1 : busy0;
  assign m_done    = sel ? done1 : done0;
  assign m_rd_en   = sel ? bus1.rd_en   : bus0.rd_en;
  assign m_rd_addr = sel ? bus1.rd_addr : bus0.rd_addr;

  typedef struct packed {
    logic [31:0]   data;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;
  exp_t sb[$];

  int busy_cnt, done_cnt, done_rel, rd_en_cnt, beat_cnt, first_rel, last_rel, max_addr, max_out;
  logic [AW-1:0] addr_log [2];
  logic          prev_stall;
  logic [31:0]   prev_data;
  logic [AW-1:0] prev_idx;

  // monitor / scoreboard checker
  always @(negedge clk) begin
    exp_t e;
    if (m_busy) busy_cnt++;
    if (m_done) begin done_cnt++; done_rel = cyc - c0 + 1; end
    if (m_rd_en) begin
      if (rd_en_cnt < 2) addr_log[rd_en_cnt] = m_rd_addr;
      rd_en_cnt++;
      if (int'(m_rd_addr) > max_addr) max_addr = int'(m_rd_addr);
    end
    if (rd_en_cnt - beat_cnt > max_out) max_out = rd_en_cnt - beat_cnt;
    if (prev_stall) begin
      tests++;
      assert (m_valid === 1'b1 && m_data === prev_data && m_idx === prev_idx)
        else begin fails++; $error("FAIL stall_hold: observed v=%0b d=%0h i=%0d expected v=1 d=%0h i=%0d",
                                   m_valid, m_data, m_idx, prev_data, prev_idx); end
    end
    if (m_valid && rdy) begin
      tests++;
      assert (sb.size() != 0)
        else begin fails++; $error("FAIL extra_beat: observed d=%0h expected no beat", m_data); end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        tests++;
        assert (m_data === e.data)
          else begin fails++; $error("FAIL beat_data: observed %0h expected %0h", m_data, e.data); end
        tests++;
        assert (m_idx === e.idx)
          else begin fails++; $error("FAIL beat_index: observed %0d expected %0d", m_idx, e.idx); end
        tests++;
        assert (m_last === e.last)
          else begin fails++; $error("FAIL beat_last: observed %0b expected %0b (idx %0d)", m_last, e.last, e.idx); end
      end
      beat_cnt++;
      if (beat_cnt == 1) first_rel = cyc - c0 + 1;
      last_rel = cyc - c0 + 1;
    end
    prev_stall = m_valid && !rdy;
    prev_data  = m_data;
    prev_idx   = m_idx;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
      else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, got, exp); end
  endtask

  task automatic mon_clear();
    busy_cnt = 0; done_cnt = 0; done_rel = 0; rd_en_cnt = 0; beat_cnt = 0;
    first_rel = 0; last_rel = 0; max_addr = 0; max_out = 0; prev_stall = 1'b0;
  endtask

  task automatic load_sb(input bit which);
    exp_t e;
    for (int i = 0; i < (which ? 8 : 16); i++) begin
      e.data = which ? {16'(6*i+4), 16'(6*i+1)} : {16'h0, 16'(3*i+1)};
      e.idx  = AW'(i);
      e.last = (i == (which ? 7 : 15));
      sb.push_back(e);
    end
  endtask

  // start high for one cycle; accepting edge is E0; returns 1ns into cycle 1
  task automatic do_start(input bit which);
    @(posedge clk); #1;
    mon_clear();
    sel = which;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    c0 = cyc;
  endtask

  // mode 0: out_ready held, mode 1: out_ready toggles every cycle
  task automatic run(input int mode, input int budget);
    for (int k = 0; k < budget && done_cnt == 0; k++) begin
      @(posedge clk); #1;
      if (mode == 1) rdy = ~rdy;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'(1));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},  64'(busy0), 64'(0));
    chk({tag, "_done"},  64'(done0), 64'(0));
    chk({tag, "_rd_en"}, 64'(bus0.rd_en), 64'(0));
    chk({tag, "_valid"}, 64'(bus0.out_valid), 64'(0));
    chk({tag, "_last"},  64'(bus0.out_last), 64'(0));
    chk({tag, "_addr"},  64'(bus0.rd_addr), 64'(0));
    chk({tag, "_index"}, 64'(bus0.out_index), 64'(0));
    chk({tag, "_data"},  64'(bus0.out_data), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem0[i] = 16'(3*i+1);
    for (int j = 0; j < 8; j++)  mem1[j] = {16'(6*j+4), 16'(6*j+1)};
    sel = 1'b0; rdy = 1'b1; start1 = 1'b0;
    mon_clear();

    // reset with start held high: outputs zero, start ignored
    rst_n = 1'b0; start0 = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk_outputs_zero("reset");
    start0 = 1'b0;
    rst_n  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset_busy", 64'(busy0), 64'(0));
    chk("idle_after_reset_rd_en", 64'(bus0.rd_en), 64'(0));

    // full rate
    rdy = 1'b1;
    load_sb(0);
    do_start(0);
    run(0, 100);
    chk("full_beats", 64'(beat_cnt), 64'(16));
    chk("full_first_cycle", 64'(first_rel), 64'(2));
    chk("full_last_cycle", 64'(last_rel), 64'(17));
    chk("full_done_cycle", 64'(done_rel), 64'(18));
    chk("full_done_pulses", 64'(done_cnt), 64'(1));
    chk("full_busy_cycles", 64'(busy_cnt), 64'(17));
    chk("full_max_addr", 64'(max_addr), 64'(15));
    chk("full_sb_empty", 64'(sb.size()), 64'(0));

    // backpressure toggle 1,0,1,0...
    rdy = 1'b1;
    load_sb(0);
    do_start(0);
    run(1, 200);
    chk("toggle_beats", 64'(beat_cnt), 64'(16));
    chk("toggle_max_addr", 64'(max_addr), 64'(15));
    chk("toggle_outstanding_le2", 64'(max_out <= 2), 64'(1));
    chk("toggle_sb_empty", 64'(sb.size()), 64'(0));

    // long stall: ready low for 10 cycles after start
    rdy = 1'b0;
    load_sb(0);
    do_start(0);
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    chk("stall_valid", 64'(bus0.out_valid), 64'(1));
    chk("stall_head", 64'(bus0.out_data), 64'(1));
    chk("stall_rd_pulses", 64'(rd_en_cnt), 64'(2));
    chk("stall_addr0", 64'(addr_log[0]), 64'(0));
    chk("stall_addr1", 64'(addr_log[1]), 64'(1));
    @(posedge clk); #1;
    rdy = 1'b1;
    run(0, 100);
    chk("stall_beats", 64'(beat_cnt), 64'(16));
    chk("stall_outstanding_le2", 64'(max_out <= 2), 64'(1));
    chk("stall_sb_empty", 64'(sb.size()), 64'(0));

    // ignored start during beat 5, then reset during beat 7
    rdy = 1'b1;
    load_sb(0);
    do_start(0);
    repeat (6) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("abort");
    chk("abort_beats_before", 64'(beat_cnt), 64'(7));
    sb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    load_sb(0);
    do_start(0);
    run(0, 100);
    chk("restart_beats", 64'(beat_cnt), 64'(16));
    chk("restart_done_cycle", 64'(done_rel), 64'(18));
    chk("restart_sb_empty", 64'(sb.size()), 64'(0));

    // two elements per beat
    rdy = 1'b1;
    load_sb(1);
    do_start(1);
    run(0, 100);
    chk("para2_beats", 64'(beat_cnt), 64'(8));
    chk("para2_first_cycle", 64'(first_rel), 64'(2));
    chk("para2_last_cycle", 64'(last_rel), 64'(9));
    chk("para2_done_cycle", 64'(done_rel), 64'(10));
    chk("para2_busy_cycles", 64'(busy_cnt), 64'(9));
    chk("para2_max_addr", 64'(max_addr), 64'(7));
    chk("para2_sb_empty", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
